// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round sequencing, answer window, hit link and HP bookkeeping for one board
module game_round_ctrl #(
    parameter int HP_MAX      = 4,
    parameter int HP_W        = 3,
    parameter int TIMEOUT     = 250000000,
    parameter int TMR_W       = 28,
    parameter int HIT_HOLD    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             READY_BTN,
    input  logic             QUE_BTN,
    input  logic             ANS_VALID,
    input  logic             ANS_CORRECT,
    input  logic             PEER_READY,
    input  logic             PEER_HIT,
    input  logic             PEER_OVER,
    output logic             READY_OUT,
    output logic             HIT_OUT,
    output logic             Q_LOAD,
    output logic [2:0]       STATE,
    output logic [HP_W-1:0]  HP,
    output logic [TMR_W-1:0] TIMER,
    output logic             GAME_OVER,
    output logic             WIN
);

    localparam int HOLD_W = $clog2(HIT_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PEER = 3'd1,
        S_QUESTION  = 3'd2,
        S_ANSWER    = 3'd3,
        S_HIT       = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] rdy_sync;
    logic [SYNC_STAGES-1:0] hit_sync;
    logic [SYNC_STAGES-1:0] over_sync;
    logic                   hit_d;

    logic [HP_W-1:0]   hp_q, hp_d, hp_after;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              win_q, win_d;

    logic peer_ready_s, peer_hit_s, peer_over_s, peer_edge;
    logic in_play, in_answer, own_wrong, own_skip, timer_expired;
    logic [2:0]      dec;
    logic [HP_W+2:0] hp_wide, dec_wide, hp_diff;

    // Peer GPIO lines are asynchronous; only the last stage of each chain is ever used.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdy_sync  <= '0;
            hit_sync  <= '0;
            over_sync <= '0;
            hit_d     <= 1'b0;
        end else begin
            rdy_sync  <= {rdy_sync[SYNC_STAGES-2:0], PEER_READY};
            hit_sync  <= {hit_sync[SYNC_STAGES-2:0], PEER_HIT};
            over_sync <= {over_sync[SYNC_STAGES-2:0], PEER_OVER};
            hit_d     <= hit_sync[SYNC_STAGES-1];
        end
    end

    assign peer_ready_s = rdy_sync[SYNC_STAGES-1];
    assign peer_hit_s   = hit_sync[SYNC_STAGES-1];
    assign peer_over_s  = over_sync[SYNC_STAGES-1];
    assign peer_edge    = peer_hit_s & ~hit_d;

    // HP loss sources for this cycle, summed and saturated at zero.
    always_comb begin
        in_play       = (state_q == S_QUESTION) || (state_q == S_ANSWER) || (state_q == S_HIT);
        in_answer     = (state_q == S_ANSWER);
        own_wrong     = in_answer & ANS_VALID & ~ANS_CORRECT;
        own_skip      = in_answer & QUE_BTN;
        // A late wrong answer can leave the timer at 0, so <= 1 still expires the window.
        timer_expired = in_answer && (timer_q <= TMR_W'(1)) && !ANS_VALID && !QUE_BTN;
        dec           = {2'b00, own_wrong} + {2'b00, own_skip} + {2'b00, timer_expired}
                      + {2'b00, in_play & peer_edge};
        hp_wide       = {3'b000, hp_q};
        dec_wide      = {{HP_W{1'b0}}, dec};
        hp_diff       = hp_wide - dec_wide;
        hp_after      = (hp_wide <= dec_wide) ? '0 : hp_diff[HP_W-1:0];
    end

    // Next-state logic: HP exhaustion beats peer loss, which beats our own correct answer.
    always_comb begin
        state_d = S_IDLE;
        hp_d    = hp_q;
        timer_d = '0;
        hold_d  = '0;
        win_d   = win_q;

        if (in_play) begin
            hp_d = hp_after;
        end

        case (state_q)
            S_IDLE: begin
                state_d = READY_BTN ? S_WAIT_PEER : S_IDLE;
            end
            S_WAIT_PEER: begin
                state_d = peer_ready_s ? S_QUESTION : S_WAIT_PEER;
            end
            S_QUESTION: begin
                timer_d = TMR_W'(TIMEOUT);
                state_d = S_ANSWER;
            end
            S_ANSWER: begin
                timer_d = (timer_q != '0) ? timer_q - TMR_W'(1) : '0;
                if (ANS_VALID && ANS_CORRECT) begin
                    state_d = S_HIT;
                end else if (QUE_BTN || timer_expired || peer_edge) begin
                    state_d = S_QUESTION;
                end else begin
                    state_d = S_ANSWER;
                end
            end
            S_HIT: begin
                hold_d  = hold_q + HOLD_W'(1);
                state_d = (hold_q == HOLD_W'(HIT_HOLD - 1)) ? S_QUESTION : S_HIT;
            end
            S_OVER: begin
                if (READY_BTN) begin
                    state_d = S_IDLE;
                    hp_d    = HP_W'(HP_MAX);
                    win_d   = 1'b0;
                end else begin
                    state_d = S_OVER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (in_play) begin
            if (hp_after == '0) begin
                state_d = S_OVER;
                win_d   = 1'b0;
            end else if (peer_over_s) begin
                state_d = S_OVER;
                win_d   = 1'b1;
            end
        end
    end

    // Round state registers; reset also truncates any HIT pulse in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            hp_q    <= HP_W'(HP_MAX);
            timer_q <= '0;
            hold_q  <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            win_q   <= win_d;
        end
    end

    assign STATE     = state_q;
    assign HP        = hp_q;
    assign TIMER     = (state_q == S_ANSWER) ? timer_q : '0;
    assign READY_OUT = (state_q == S_WAIT_PEER) || in_play;
    assign HIT_OUT   = (state_q == S_HIT);
    assign Q_LOAD    = (state_q == S_QUESTION);
    assign GAME_OVER = (state_q == S_OVER);
    assign WIN       = win_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - directed self-checking bench for game_round_ctrl
module tb_game_round_ctrl;

    logic       clk = 1'b0;
    logic       rst, ready_btn, que_btn, ans_valid, ans_correct;
    logic       peer_ready, peer_hit, peer_over;
    logic       ready_out, hit_out, q_load, game_over, win;
    logic [2:0] state;
    logic [2:0] hp;
    logic [7:0] timer;

    int total = 0;
    int bad   = 0;

    game_round_ctrl #(
        .HP_MAX(3), .HP_W(3), .TIMEOUT(20), .TMR_W(8), .HIT_HOLD(4), .SYNC_STAGES(2)
    ) dut (
        .CLK(clk), .RST(rst), .READY_BTN(ready_btn), .QUE_BTN(que_btn),
        .ANS_VALID(ans_valid), .ANS_CORRECT(ans_correct), .PEER_READY(peer_ready),
        .PEER_HIT(peer_hit), .PEER_OVER(peer_over), .READY_OUT(ready_out),
        .HIT_OUT(hit_out), .Q_LOAD(q_load), .STATE(state), .HP(hp), .TIMER(timer),
        .GAME_OVER(game_over), .WIN(win)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got %0d want 0", state); end
        total++; if (hp !== 3'd3) begin bad++; $display("FAIL reset_hp got %0d want 3", hp); end
        total++; if (timer !== 8'd0) begin bad++; $display("FAIL reset_timer got %0d want 0", timer); end
        total++; if ({ready_out, hit_out, q_load, game_over, win} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got %b want 00000", {ready_out, hit_out, q_load, game_over, win});
        end
        rst = 1'b0;
    endtask

    task automatic test_start();
        ready_btn  = 1'b1;
        peer_ready = 1'b1;
        tick();
        ready_btn = 1'b0;
        total++; if (state !== 3'd1) begin bad++; $display("FAIL start_wait got %0d want 1", state); end
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL start_ready_out got %b want 1", ready_out); end
        tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL start_sync_delay got %0d want 1", state); end
        tick();
        total++; if (state !== 3'd2 || q_load !== 1'b1) begin
            bad++; $display("FAIL start_question got state=%0d qload=%b want 2,1", state, q_load);
        end
        tick();
        total++; if (state !== 3'd3 || q_load !== 1'b0 || timer !== 8'd20) begin
            bad++; $display("FAIL start_answer got state=%0d qload=%b timer=%0d want 3,0,20", state, q_load, timer);
        end
        tick();
        total++; if (timer !== 8'd19) begin bad++; $display("FAIL start_countdown got %0d want 19", timer); end
    endtask

    task automatic start_round();
        int n;
        ready_btn = 1'b1;
        tick();
        ready_btn = 1'b0;
        n = 0;
        while (state !== 3'd3 && n < 10) begin
            tick();
            n++;
        end
        total++; if (state !== 3'd3 || timer !== 8'd20) begin
            bad++; $display("FAIL start_round got state=%0d timer=%0d want 3,20", state, timer);
        end
    endtask

    task automatic test_correct_hit();
        int n;
        for (int i = 0; i < 40 && timer !== 8'd10; i++) tick();
        total++; if (timer !== 8'd10) begin bad++; $display("FAIL hit_timer10 got %0d want 10", timer); end
        ans_valid = 1'b1; ans_correct = 1'b1;
        tick();
        ans_valid = 1'b0; ans_correct = 1'b0;
        n = 0;
        while (hit_out === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        total++; if (n !== 4) begin bad++; $display("FAIL hit_width got %0d want 4", n); end
        total++; if (state !== 3'd2 || q_load !== 1'b1) begin
            bad++; $display("FAIL hit_then_question got state=%0d qload=%b want 2,1", state, q_load);
        end
        total++; if (hp !== 3'd3) begin bad++; $display("FAIL hit_hp got %0d want 3", hp); end
        tick();
        total++; if (state !== 3'd3 || timer !== 8'd20) begin
            bad++; $display("FAIL hit_reanswer got state=%0d timer=%0d want 3,20", state, timer);
        end
    endtask

    task automatic test_hp_to_zero();
        int n;
        int last;
        ans_valid = 1'b1; ans_correct = 1'b0;
        tick();
        ans_valid = 1'b0;
        total++; if (hp !== 3'd2 || state !== 3'd3) begin
            bad++; $display("FAIL wrong1 got hp=%0d state=%0d want 2,3", hp, state);
        end
        ans_valid = 1'b1;
        tick();
        ans_valid = 1'b0;
        total++; if (hp !== 3'd1 || state !== 3'd3) begin
            bad++; $display("FAIL wrong2 got hp=%0d state=%0d want 1,3", hp, state);
        end
        last = 99;
        n = 0;
        while (state === 3'd3 && n < 40) begin
            last = int'(timer);
            tick();
            n++;
        end
        total++; if (last !== 1) begin bad++; $display("FAIL timeout_last_timer got %0d want 1", last); end
        total++; if (state !== 3'd5 || hp !== 3'd0) begin
            bad++; $display("FAIL timeout_over got state=%0d hp=%0d want 5,0", state, hp);
        end
        total++; if ({game_over, win, ready_out, hit_out} !== 4'b1000 || timer !== 8'd0) begin
            bad++; $display("FAIL over_flags got go/win/rdy/hit=%b timer=%0d want 1000,0",
                            {game_over, win, ready_out, hit_out}, timer);
        end
        ready_btn = 1'b1;
        tick();
        ready_btn = 1'b0;
        total++; if (state !== 3'd0 || hp !== 3'd3 || game_over !== 1'b0) begin
            bad++; $display("FAIL over_restart got state=%0d hp=%0d go=%b want 0,3,0", state, hp, game_over);
        end
    endtask

    task automatic test_saturate();
        start_round();
        for (int i = 0; i < 2; i++) begin
            ans_valid = 1'b1; ans_correct = 1'b0;
            tick();
            ans_valid = 1'b0;
        end
        total++; if (hp !== 3'd1) begin bad++; $display("FAIL sat_setup got %0d want 1", hp); end
        peer_hit = 1'b1;
        tick();
        tick();
        ans_valid = 1'b1;
        tick();
        ans_valid = 1'b0;
        peer_hit  = 1'b0;
        total++; if (hp !== 3'd0 || state !== 3'd5 || win !== 1'b0) begin
            bad++; $display("FAIL sat_hp1 got hp=%0d state=%0d win=%b want 0,5,0", hp, state, win);
        end
        ready_btn = 1'b1;
        tick();
        ready_btn = 1'b0;
        start_round();
        ans_valid = 1'b1;
        tick();
        ans_valid = 1'b0;
        total++; if (hp !== 3'd2) begin bad++; $display("FAIL sat2_setup got %0d want 2", hp); end
        peer_hit = 1'b1;
        tick();
        tick();
        ans_valid = 1'b1;
        tick();
        ans_valid = 1'b0;
        peer_hit  = 1'b0;
        total++; if (hp !== 3'd0 || state !== 3'd5) begin
            bad++; $display("FAIL sat_hp2 got hp=%0d state=%0d want 0,5", hp, state);
        end
        ready_btn = 1'b1;
        tick();
        ready_btn = 1'b0;
    endtask

    task automatic test_peer_over();
        int n;
        start_round();
        ans_valid = 1'b1; ans_correct = 1'b0;
        tick();
        ans_valid = 1'b0;
        peer_over = 1'b1;
        n = 0;
        while (state !== 3'd5 && n < 10) begin
            tick();
            n++;
        end
        total++; if (n !== 3) begin bad++; $display("FAIL peer_over_latency got %0d want 3", n); end
        total++; if (win !== 1'b1 || hp !== 3'd2 || game_over !== 1'b1 || ready_out !== 1'b0) begin
            bad++; $display("FAIL peer_over_win got win=%b hp=%0d go=%b rdy=%b want 1,2,1,0",
                            win, hp, game_over, ready_out);
        end
        peer_over = 1'b0;
        ready_btn = 1'b1;
        tick();
        ready_btn = 1'b0;
        total++; if (state !== 3'd0 || hp !== 3'd3 || win !== 1'b0) begin
            bad++; $display("FAIL peer_over_restart got state=%0d hp=%0d win=%b want 0,3,0", state, hp, win);
        end
    endtask

    task automatic test_skip_and_peer();
        start_round();
        que_btn = 1'b1;
        tick();
        que_btn = 1'b0;
        total++; if (state !== 3'd2 || q_load !== 1'b1 || hp !== 3'd2) begin
            bad++; $display("FAIL skip got state=%0d qload=%b hp=%0d want 2,1,2", state, q_load, hp);
        end
        tick();
        total++; if (state !== 3'd3 || timer !== 8'd20) begin
            bad++; $display("FAIL skip_reanswer got state=%0d timer=%0d want 3,20", state, timer);
        end
        peer_hit = 1'b1;
        tick();
        tick();
        tick();
        total++; if (state !== 3'd2 || hp !== 3'd1) begin
            bad++; $display("FAIL peer_edge_answer got state=%0d hp=%0d want 2,1", state, hp);
        end
        peer_hit = 1'b0;
    endtask

    task automatic test_reset_mid_hit();
        tick();
        ans_valid = 1'b1; ans_correct = 1'b1;
        tick();
        ans_valid = 1'b0; ans_correct = 1'b0;
        total++; if (hit_out !== 1'b1) begin bad++; $display("FAIL rst_hit1 got %b want 1", hit_out); end
        tick();
        total++; if (hit_out !== 1'b1) begin bad++; $display("FAIL rst_hit2 got %b want 1", hit_out); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (hit_out !== 1'b0 || state !== 3'd0 || hp !== 3'd3 || timer !== 8'd0) begin
            bad++; $display("FAIL rst_mid_hit got hit=%b state=%0d hp=%0d timer=%0d want 0,0,3,0",
                            hit_out, state, hp, timer);
        end
        peer_hit = 1'b1;
        repeat (4) tick();
        peer_hit = 1'b0;
        total++; if (hp !== 3'd3 || state !== 3'd0) begin
            bad++; $display("FAIL idle_peer_edge got hp=%0d state=%0d want 3,0", hp, state);
        end
    endtask

    initial begin
        rst = 1'b1; ready_btn = 1'b0; que_btn = 1'b0; ans_valid = 1'b0; ans_correct = 1'b0;
        peer_ready = 1'b0; peer_hit = 1'b0; peer_over = 1'b0;
        test_reset();
        test_start();
        test_correct_hit();
        test_hp_to_zero();
        test_saturate();
        test_peer_over();
        test_skip_and_peer();
        test_reset_mid_hit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
